// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin arbiter slice.
package arb_pkg;

  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned CNT_W = 8;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; output is all-zero when disabled.
module onehot_dec3
  import arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arb8_ctrl.sv
// Round-robin arbiter for 8 requesters sharing one one-hot select, with a
// tenure limit that preempts long holders and a mandatory dead cycle per release.
module rr_arb8_ctrl
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned N_REQ    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             preempt,
  output logic [IDX_W-1:0] ptr
);

  localparam cnt_t MaxHold = cnt_t'(MAX_HOLD);

  state_e state_q, state_d;
  idx_t   idx_q, idx_d;
  idx_t   ptr_q, ptr_d;
  cnt_t   cnt_q, cnt_d;
  logic   pre_q, pre_d;
  logic   timeout;

  // First set request scanning upward from the pointer, wrapping mod 8.
  function automatic idx_t rr_pick(input logic [N_REQ-1:0] r, input idx_t p);
    idx_t w;
    idx_t c;
    logic found;
    w     = p;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      c = p + idx_t'(i);
      if (!found && r[c]) begin
        w     = c;
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign timeout = (MAX_HOLD != 0) && (cnt_q == MaxHold);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pre_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          idx_d   = rr_pick(req, ptr_q);
          cnt_d   = cnt_t'(1);
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[idx_q] || timeout) begin
          // An owner dropping on the timeout edge counts as a plain release.
          state_d = IDLE;
          ptr_d   = idx_q + idx_t'(1);
          cnt_d   = '0;
          pre_d   = req[idx_q];
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
    end
  end

  assign gnt_vld = (state_q == GRANT);
  assign gnt_idx = idx_q;
  assign preempt = pre_q;
  assign ptr     = ptr_q;

  onehot_dec3 u_dec (
    .idx    (idx_q),
    .en     (gnt_vld),
    .onehot (gnt)
  );

endmodule

// File: tb/tb_rr_arb8_ctrl.sv
// Bench for rr_arb8_ctrl: directed vector table, corner sequences and random
// traffic checked against an integer-level reference model (MAX_HOLD 4 and 3).
module tb_rr_arb8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;

  logic [7:0] gnt4, gnt3;
  logic [2:0] idx4, idx3, ptr4, ptr3;
  logic       vld4, vld3, pre4, pre3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arb8_ctrl #(.MAX_HOLD(4), .N_REQ(8)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt4),
    .gnt_idx (idx4),
    .gnt_vld (vld4),
    .preempt (pre4),
    .ptr     (ptr4)
  );

  rr_arb8_ctrl #(.MAX_HOLD(3), .N_REQ(8)) dut3 (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt3),
    .gnt_idx (idx3),
    .gnt_vld (vld3),
    .preempt (pre3),
    .ptr     (ptr3)
  );

  // Reference model: owner is -1 when idle, tenure counts granted cycles.
  typedef struct {
    int owner;
    int tenure;
    int ptr;
    bit pre;
  } model_t;

  model_t m4 = '{-1, 0, 0, 1'b0};
  model_t m3 = '{-1, 0, 0, 1'b0};

  function automatic model_t step(input model_t s, input logic [7:0] r, input logic rn,
                                  input int maxhold);
    model_t n;
    n = s;
    n.pre = 1'b0;
    if (!rn) begin
      n = '{-1, 0, 0, 1'b0};
    end else if (s.owner < 0) begin
      for (int k = 0; k < 8; k++) begin
        if (n.owner < 0 && r[(s.ptr + k) % 8]) begin
          n.owner  = (s.ptr + k) % 8;
          n.tenure = 1;
        end
      end
    end else if (!r[s.owner] || (maxhold != 0 && s.tenure == maxhold)) begin
      n.pre    = r[s.owner];
      n.ptr    = (s.owner + 1) % 8;
      n.owner  = -1;
      n.tenure = 0;
    end else begin
      n.tenure = (s.tenure < 255) ? s.tenure + 1 : 255;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m4 <= step(m4, req, rst_n, 4);
    m3 <= step(m3, req, rst_n, 3);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    chk("d4.gnt", int'(gnt4), (m4.owner >= 0) ? (1 << m4.owner) : 0);
    chk("d4.vld", int'(vld4), int'(m4.owner >= 0));
    chk("d4.ptr", int'(ptr4), m4.ptr);
    chk("d4.preempt", int'(pre4), int'(m4.pre));
    if (m4.owner >= 0) chk("d4.idx", int'(idx4), m4.owner);
    chk("d3.gnt", int'(gnt3), (m3.owner >= 0) ? (1 << m3.owner) : 0);
    chk("d3.vld", int'(vld3), int'(m3.owner >= 0));
    chk("d3.ptr", int'(ptr3), m3.ptr);
    chk("d3.preempt", int'(pre3), int'(m3.pre));
    if (m3.owner >= 0) chk("d3.idx", int'(idx3), m3.owner);
  endtask

  // Drive one cycle of inputs, let one rising edge pass, then compare.
  task automatic cyc(input logic rn, input logic [7:0] r);
    rst_n = rn;
    req   = r;
    @(negedge clk);
    check_models();
  endtask

  typedef struct {
    logic       rn;
    logic [7:0] r;
    logic [7:0] e_gnt;
    logic       e_vld;
    logic [2:0] e_idx;
    logic [2:0] e_ptr;
    logic       e_pre;
  } vec_t;

  vec_t vecs[28];

  int   order[$];
  int   npre;
  logic prev_vld;

  initial begin
    // Expected outputs of the MAX_HOLD=4 instance after each row's edge.
    vecs[0]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 8'hFF, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[2]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[3]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[4]  = '{1'b1, 8'h10, 8'h10, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[5]  = '{1'b1, 8'h10, 8'h10, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[6]  = '{1'b1, 8'h10, 8'h10, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 8'h10, 8'h10, 1'b1, 3'd4, 3'd0, 1'b0};
    vecs[8]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd5, 1'b0};
    vecs[9]  = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd5, 1'b0};
    vecs[10] = '{1'b1, 8'h40, 8'h40, 1'b1, 3'd6, 3'd5, 1'b0};
    vecs[11] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd7, 1'b0};
    vecs[12] = '{1'b1, 8'h81, 8'h80, 1'b1, 3'd7, 3'd7, 1'b0};
    vecs[13] = '{1'b1, 8'h01, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[14] = '{1'b1, 8'h01, 8'h01, 1'b1, 3'd0, 3'd0, 1'b0};
    vecs[15] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd1, 1'b0};
    vecs[16] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 3'd1, 1'b0};
    vecs[17] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 3'd1, 1'b0};
    vecs[18] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 3'd1, 1'b0};
    vecs[19] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 3'd1, 1'b0};
    vecs[20] = '{1'b1, 8'h04, 8'h00, 1'b0, 3'd0, 3'd3, 1'b1};
    vecs[21] = '{1'b1, 8'h04, 8'h04, 1'b1, 3'd2, 3'd3, 1'b0};
    vecs[22] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd3, 1'b0};
    vecs[23] = '{1'b1, 8'h20, 8'h20, 1'b1, 3'd5, 3'd3, 1'b0};
    vecs[24] = '{1'b1, 8'h20, 8'h20, 1'b1, 3'd5, 3'd3, 1'b0};
    vecs[25] = '{1'b0, 8'h20, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    vecs[26] = '{1'b1, 8'h20, 8'h20, 1'b1, 3'd5, 3'd0, 1'b0};
    vecs[27] = '{1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 3'd6, 1'b0};

    for (int i = 0; i < 28; i++) begin
      cyc(vecs[i].rn, vecs[i].r);
      chk($sformatf("vec%0d.gnt", i), int'(gnt4), int'(vecs[i].e_gnt));
      chk($sformatf("vec%0d.vld", i), int'(vld4), int'(vecs[i].e_vld));
      chk($sformatf("vec%0d.ptr", i), int'(ptr4), int'(vecs[i].e_ptr));
      chk($sformatf("vec%0d.preempt", i), int'(pre4), int'(vecs[i].e_pre));
      if (vecs[i].e_vld) chk($sformatf("vec%0d.idx", i), int'(idx4), int'(vecs[i].e_idx));
    end

    // Fairness with all requesting: 9 grants 0..7,0 and 9 preempts in 45 cycles.
    cyc(1'b0, 8'h00);
    prev_vld = 1'b0;
    npre     = 0;
    for (int c = 1; c <= 45; c++) begin
      cyc(1'b1, 8'hFF);
      if (vld4 && !prev_vld) order.push_back(int'(idx4));
      if (pre4) npre++;
      prev_vld = vld4;
    end
    chk("fair.ngrants", order.size(), 9);
    for (int k = 0; k < order.size() && k < 9; k++)
      chk($sformatf("fair.order%0d", k), order[k], k % 8);
    chk("fair.npreempt", npre, 9);

    // MAX_HOLD=3: owner drop on the timeout edge, then held through timeout.
    cyc(1'b0, 8'h00);
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'h04);
    chk("tmo.held3.vld", int'(vld3), 1);
    cyc(1'b1, 8'h00);
    chk("tmo.drop.preempt", int'(pre3), 0);
    chk("tmo.drop.vld", int'(vld3), 0);
    chk("tmo.drop.ptr", int'(ptr3), 3);
    for (int c = 0; c < 3; c++) cyc(1'b1, 8'h04);
    cyc(1'b1, 8'h04);
    chk("tmo.held.preempt", int'(pre3), 1);
    chk("tmo.held.vld", int'(vld3), 0);
    chk("tmo.held.ptr", int'(ptr3), 3);
    cyc(1'b1, 8'h04);
    chk("tmo.regrant.preempt", int'(pre3), 0);
    chk("tmo.regrant.gnt", int'(gnt3), 8'h04);

    // Random traffic with sticky requests and occasional resets.
    for (int c = 0; c < 600; c++) begin
      logic [7:0] r;
      r = req;
      if ($urandom_range(0, 3) == 0)
        r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 59) != 0), r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
